// File: rtl/clk_en_pkg.sv
// Shared types and helpers for the clock-enable divider bank.
package clk_en_pkg;

  typedef enum logic [1:0] {
    S_RST,
    S_SETTLE,
    S_LOCKED
  } fsm_t;

  localparam int CNT_W_DEF = 16;
  localparam int N_CH_DEF  = 4;

  typedef logic [CNT_W_DEF-1:0] div_t;

  // Width of a channel select, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = ch_width(N_CH_DEF);

endpackage

// File: rtl/clk_en_channel.sv
// One divider channel: period counter, pending/active ratio registers,
// wrap-aligned commit, registered strobe and square-wave outputs.
// Optional interval watchdog enabled by CLK_EN_RATIO_CHECK_EN.
module clk_en_channel
  import clk_en_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DIV_RST = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             ce_o,
  output logic             div_clk_o,
  output logic [CNT_W-1:0] active_div_o,
  output logic             pending_o,
  output logic             err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ce_q, ce_d;
  logic             dclk_q, dclk_d;
  logic             wrap;
  logic             commit;
  logic [CNT_W:0]   half;

  // Counter, commit and output next-state; outputs lag the counter by one register stage.
  always_comb begin
    wrap       = (active_q != '0) && (cnt_q == active_q - 1'b1);
    commit     = pend_vld_q && (wrap || (active_q == '0));
    half       = ({1'b0, active_q} + 1'b1) >> 1;
    cnt_d      = (wrap || (active_q == '0)) ? '0 : cnt_q + 1'b1;
    active_d   = commit ? pend_q : active_q;
    pend_d     = wr_en_i ? wr_div_i : pend_q;
    pend_vld_d = wr_en_i ? 1'b1 : (commit ? 1'b0 : pend_vld_q);
    ce_d       = wrap;
    dclk_d     = (active_q != '0) && ({1'b0, cnt_q} < half);
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      active_q   <= CNT_W'(DIV_RST);
      pend_q     <= CNT_W'(DIV_RST);
      pend_vld_q <= 1'b0;
      ce_q       <= 1'b0;
      dclk_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ce_q       <= ce_d;
      dclk_q     <= dclk_d;
    end
  end

  assign ce_o         = ce_q;
  assign div_clk_o    = dclk_q;
  assign active_div_o = active_q;
  assign pending_o    = pend_vld_q;

`ifdef CLK_EN_RATIO_CHECK_EN
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             armed_q, armed_d;
  logic             err_q, err_d;

  // Watchdog: measure strobe-to-strobe spacing; a commit disarms so the first new period is skipped.
  always_comb begin
    wd_d    = wd_q;
    armed_d = armed_q;
    err_d   = err_q;
    if (ce_d && armed_q && (({1'b0, wd_q} + 1'b1) != {1'b0, active_q})) begin
      err_d = 1'b1;
    end
    if (commit) begin
      wd_d    = '0;
      armed_d = 1'b0;
    end else if (ce_d) begin
      wd_d    = '0;
      armed_d = 1'b1;
    end else if (wd_q != '1) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Watchdog registers; the error flag is sticky until reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_q    <= '0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/clk_en_divider_bank.sv
// Bank of N_CH programmable clock-enable dividers on clk100 with a
// settle/lock sequencer and a status LED driven by one channel.
// Optional ratio checker per channel enabled by CLK_EN_RATIO_CHECK_EN.
module clk_en_divider_bank
  import clk_en_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_RST     = 10,
  parameter int LOCK_CYCLES = 64,
  parameter int LED_CH      = 0,
  parameter int LED_TOGGLE  = 5_000_000
) (
  input  logic                      clk100,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ch_width(N_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_div,
  output logic [N_CH-1:0]           ce_out,
  output logic [N_CH-1:0]           div_clk,
  output logic                      locked,
  output logic                      led,
  output logic [N_CH-1:0]           err
);

  localparam int CFG_CH_W = ch_width(N_CH);
  localparam int LOCK_W   = $clog2(LOCK_CYCLES + 1);
  localparam int LED_W    = (LED_TOGGLE > 1) ? $clog2(LED_TOGGLE) : 1;

  fsm_t              state_q, state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;
  logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
  logic              led_q, led_d;

  logic              cfg_acc;
  logic [N_CH-1:0]   wr_en;
  logic [N_CH-1:0]   pending;
  logic              any_change;
  logic [CNT_W-1:0]  active_div [N_CH];

  assign cfg_ready = (state_q != S_RST);
  assign cfg_acc   = cfg_valid && cfg_ready;

  // Decode the write to its channel; out-of-range selects match nothing and are dropped.
  always_comb begin
    wr_en      = '0;
    any_change = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_acc && (cfg_ch == CFG_CH_W'(i))) begin
        wr_en[i] = 1'b1;
        if (cfg_div != active_div[i]) begin
          any_change = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    clk_en_channel #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_i        (clk100),
      .rst_ni       (rst),
      .wr_en_i      (wr_en[i]),
      .wr_div_i     (cfg_div),
      .ce_o         (ce_out[i]),
      .div_clk_o    (div_clk[i]),
      .active_div_o (active_div[i]),
      .pending_o    (pending[i]),
      .err_o        (err[i])
    );
  end

  // Lock sequencer: settle counter runs only while no ratio change is waiting to commit.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      S_RST: begin
        state_d    = S_SETTLE;
        lock_cnt_d = '0;
      end
      S_SETTLE: begin
        if ((|wr_en) || (|pending)) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
          state_d    = S_LOCKED;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      S_LOCKED: begin
        lock_cnt_d = '0;
        if (any_change) begin
          state_d = S_SETTLE;
        end
      end
      default: begin
        state_d    = S_RST;
        lock_cnt_d = '0;
      end
    endcase
    locked_d = (state_d == S_LOCKED);
  end

  // Sequencer registers with synchronous active-low reset.
  always_ff @(posedge clk100) begin
    if (!rst) begin
      state_q    <= S_RST;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // LED prescaler counts strobes of the LED channel and holds while that channel is stopped.
  always_comb begin
    led_cnt_d = led_cnt_q;
    led_d     = led_q;
    if (ce_out[LED_CH] && (active_div[LED_CH] != '0)) begin
      if (led_cnt_q == LED_W'(LED_TOGGLE - 1)) begin
        led_cnt_d = '0;
        led_d     = ~led_q;
      end else begin
        led_cnt_d = led_cnt_q + 1'b1;
      end
    end
  end

  // LED registers with synchronous active-low reset.
  always_ff @(posedge clk100) begin
    if (!rst) begin
      led_cnt_q <= '0;
      led_q     <= 1'b0;
    end else begin
      led_cnt_q <= led_cnt_d;
      led_q     <= led_d;
    end
  end

  assign locked = locked_q;
  assign led    = led_q;

endmodule

// File: tb/tb_clk_en_divider_bank.sv
// Directed bench for clk_en_divider_bank: main bank with N_CH=4 and a
// second N_CH=3 bank for the out-of-range channel select.
module tb_clk_en_divider_bank;
  import clk_en_pkg::*;

  logic       clk100 = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  div_t       cfg_div;
  logic [3:0] ce_out, div_clk, err;
  logic       locked, led;

  logic       cfg3_valid;
  logic       cfg3_ready;
  logic [1:0] cfg3_ch;
  div_t       cfg3_div;
  logic [2:0] ce3, dclk3, err3;
  logic       locked3, led3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk100 = ~clk100;

  clk_en_divider_bank #(
    .N_CH(4), .CNT_W(16), .DIV_RST(10), .LOCK_CYCLES(64), .LED_CH(0), .LED_TOGGLE(3)
  ) u_dut (
    .clk100(clk100), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .ce_out(ce_out), .div_clk(div_clk),
    .locked(locked), .led(led), .err(err)
  );

  clk_en_divider_bank #(
    .N_CH(3), .CNT_W(16), .DIV_RST(10), .LOCK_CYCLES(64), .LED_CH(0), .LED_TOGGLE(3)
  ) u_dut3 (
    .clk100(clk100), .rst(rst), .cfg_valid(cfg3_valid), .cfg_ready(cfg3_ready),
    .cfg_ch(cfg3_ch), .cfg_div(cfg3_div), .ce_out(ce3), .div_clk(dclk3),
    .locked(locked3), .led(led3), .err(err3)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one config request to the main bank for the next edge.
  task automatic applyStimulus(input logic valid, input int ch, input int div);
    cfg_valid = valid;
    cfg_ch    = CH_W'(ch);
    cfg_div   = div_t'(div);
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
    cyc++;
  endtask

  // Reference: ratio-10 channel, k = edges since reset release.
  function automatic logic ce10(input int k);
    return (k >= 10) && (k % 10 == 0);
  endfunction

  function automatic logic dc10(input int k);
    return ((k - 1) % 10) < 5;
  endfunction

  // Scheduled ratio changes: ch1 -> 4 at E80, ch2 -> 0 at E150 then 1 at E157, ch3 -> 3 at E230.
  function automatic logic [3:0] expCe(input int k);
    logic [3:0] v;
    v[0] = ce10(k);
    v[1] = (k <= 80)  ? ce10(k) : ((k - 80) % 4 == 0);
    v[2] = (k <= 150) ? ce10(k) : (k >= 158);
    v[3] = (k <= 230) ? ce10(k) : ((k - 230) % 3 == 0);
    return v;
  endfunction

  function automatic logic [3:0] expDc(input int k);
    logic [3:0] v;
    v[0] = dc10(k);
    v[1] = (k <= 80)  ? dc10(k) : (((k - 81) % 4) < 2);
    v[2] = (k <= 150) ? dc10(k) : (k >= 158);
    v[3] = (k <= 230) ? dc10(k) : (((k - 231) % 3) < 2);
    return v;
  endfunction

  function automatic logic expLocked(input int k);
    return ((k >= 65) && (k <= 73)) || ((k >= 144) && (k <= 145)) ||
           (k == 221) || (k >= 294);
  endfunction

  function automatic logic expLed(input int k);
    return (((k - 1) / 30) % 2) == 1;
  endfunction

  // Expect every output at its reset value on both banks.
  task automatic checkResetState();
    checkOutput("rst_ce_out",    ce_out,    4'h0);
    checkOutput("rst_div_clk",   div_clk,   4'h0);
    checkOutput("rst_locked",    locked,    1'b0);
    checkOutput("rst_led",       led,       1'b0);
    checkOutput("rst_err",       err,       4'h0);
    checkOutput("rst_cfg_ready", cfg_ready, 1'b0);
    checkOutput("rst_ce3",       ce3,       3'h0);
    checkOutput("rst_locked3",   locked3,   1'b0);
  endtask

  initial begin
    rst        = 1'b0;
    cfg3_valid = 1'b0;
    cfg3_ch    = 2'd0;
    cfg3_div   = '0;
    applyStimulus(1'b0, 0, 0);
    tick();
    tick();
    checkResetState();

    rst = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 295; k++) begin
      tick();
      checkOutput("ce_out",    ce_out,    expCe(k));
      checkOutput("div_clk",   div_clk,   expDc(k));
      checkOutput("locked",    locked,    expLocked(k));
      checkOutput("led",       led,       expLed(k));
      checkOutput("err",       err,       4'h0);
      checkOutput("cfg_ready", cfg_ready, 1'b1);
      checkOutput("ce3",       ce3,       {3{ce10(k)}});
      checkOutput("locked3",   locked3,   (k >= 65));
      applyStimulus(1'b0, 0, 0);
      cfg3_valid = 1'b0;
      case (k)
        73: begin
          applyStimulus(1'b1, 1, 4);
          cfg3_valid = 1'b1;
          cfg3_ch    = 2'd3;
          cfg3_div   = 16'd2;
        end
        145: applyStimulus(1'b1, 2, 0);
        155: applyStimulus(1'b1, 2, 1);
        221: applyStimulus(1'b1, 3, 7);
        222: applyStimulus(1'b1, 3, 3);
        default: ;
      endcase
    end

    // Queue a ch0 change, then reset before it can commit.
    applyStimulus(1'b1, 0, 5);
    tick();
    applyStimulus(1'b0, 0, 0);
    checkOutput("pre_rst_locked", locked, 1'b0);
    checkOutput("pre_rst_led",    led,    1'b1);
    rst = 1'b0;
    tick();
    checkResetState();

    rst = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput("rel_ce_out",    ce_out,    {4{ce10(k)}});
      checkOutput("rel_div_clk",   div_clk,   {4{dc10(k)}});
      checkOutput("rel_locked",    locked,    1'b0);
      checkOutput("rel_cfg_ready", cfg_ready, 1'b1);
    end

`ifdef CLK_EN_RATIO_CHECK_EN
    force u_dut.gen_ch[0].u_ch.cnt_q = 16'd7;
    #1;
    release u_dut.gen_ch[0].u_ch.cnt_q;
    repeat (10) tick();
    checkOutput("err_set", err, 4'h1);
    repeat (5) tick();
    checkOutput("err_sticky", err, 4'h1);
`else
    repeat (10) tick();
    checkOutput("err_tied", err, 4'h0);
`endif

    rst = 1'b0;
    tick();
    checkOutput("err_cleared", err, 4'h0);
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
